// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite bus bundle used by axi_lite_master_bridge; master drives AW/W/AR payloads and B/R ready.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface axi_lite_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `AXI_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master bridging the core load/store request port.
// Define AXI_MASTER_RESP_CHECK_EN to report non-OKAY BRESP/RRESP on RSP_ERR.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `AXI_DATA_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic                    RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  axi_lite_master_bridge_if.master M_AXI
);
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD} state_t;

  state_t                  state, state_n;
  logic                    awvalid_q, awvalid_n;
  logic                    wvalid_q, wvalid_n;
  logic                    arvalid_q, arvalid_n;
  logic                    bready_q, bready_n;
  logic                    rready_q, rready_n;
  logic                    rsp_valid_q, rsp_valid_n;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    accept, b_fire, r_fire;

  assign REQ_READY = (state == IDLE);
  assign accept    = REQ_VALID & REQ_READY;
  assign b_fire    = bready_q & M_AXI.BVALID;
  assign r_fire    = rready_q & M_AXI.RVALID;

  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.AWVALID = awvalid_q;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = wstrb_q;
  assign M_AXI.WVALID  = wvalid_q;
  assign M_AXI.BREADY  = bready_q;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARPROT  = 3'b000;
  assign M_AXI.ARVALID = arvalid_q;
  assign M_AXI.RREADY  = rready_q;

  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rdata_q;

  always_comb begin
    state_n     = state;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    arvalid_n   = arvalid_q;
    bready_n    = bready_q;
    rready_n    = rready_q;
    rsp_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (REQ_WE) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RA;
            arvalid_n = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W retire independently; a low VALID here means that channel is already done.
        awvalid_n = awvalid_q & ~M_AXI.AWREADY;
        wvalid_n  = wvalid_q & ~M_AXI.WREADY;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WB;
          bready_n = 1'b1;
        end
      end
      WB: begin
        if (b_fire) begin
          state_n     = IDLE;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
        end
      end
      RA: begin
        if (M_AXI.ARREADY) begin
          state_n   = RD;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RD: begin
        if (r_fire) begin
          state_n     = IDLE;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state       <= state_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      arvalid_q   <= arvalid_n;
      bready_q    <= bready_n;
      rready_q    <= rready_n;
      rsp_valid_q <= rsp_valid_n;
      if (accept) begin
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        wstrb_q <= REQ_WSTRB;
      end
      if (r_fire) begin
        rdata_q <= M_AXI.RDATA;
      end
    end
  end

`ifdef AXI_MASTER_RESP_CHECK_EN
  logic rsp_err_q, rsp_err_n;

  always_comb begin
    rsp_err_n = 1'b0;
    if (b_fire) begin
      rsp_err_n = (M_AXI.BRESP != 2'b00);
    end else if (r_fire) begin
      rsp_err_n = (M_AXI.RRESP != 2'b00);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_n;
    end
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign RSP_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge against a small in-bench AXI4-Lite memory slave.
module tb_axi_lite_master_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic [3:0]    REQ_WSTRB = '0;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  axi_lite_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axi_lite_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_WSTRB (REQ_WSTRB),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .M_AXI     (m_if.master)
  );

  // Slave knobs
  int unsigned aw_delay = 0, w_delay = 0, r_delay = 0;
  logic        b_hold = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;

  // Slave state
  int unsigned aw_cnt, w_cnt, r_cnt;
  logic        aw_got, w_got, b_pend;
  logic [31:0] sa_addr, sw_data, rd_addr;
  logic [3:0]  sw_strb;
  logic [31:0] mem [16];

  logic        aw_fire, w_fire, commit;
  logic [31:0] c_addr, c_data;
  logic [3:0]  c_strb;

  assign m_if.AWREADY = m_if.AWVALID && (aw_cnt >= aw_delay);
  assign m_if.WREADY  = m_if.WVALID && (w_cnt >= w_delay);
  assign m_if.ARREADY = m_if.ARVALID;
  assign aw_fire = m_if.AWVALID && m_if.AWREADY;
  assign w_fire  = m_if.WVALID && m_if.WREADY;
  assign commit  = (aw_got || aw_fire) && (w_got || w_fire);
  assign c_addr  = aw_got ? sa_addr : m_if.AWADDR;
  assign c_data  = w_got ? sw_data : m_if.WDATA;
  assign c_strb  = w_got ? sw_strb : m_if.WSTRB;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      sa_addr <= '0; sw_data <= '0; sw_strb <= '0; rd_addr <= '0;
      m_if.BVALID <= 1'b0; m_if.BRESP <= 2'b00;
      m_if.RVALID <= 1'b0; m_if.RRESP <= 2'b00; m_if.RDATA <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (aw_fire) aw_cnt <= 0; else if (m_if.AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_fire) w_cnt <= 0; else if (m_if.WVALID) w_cnt <= w_cnt + 1;
      if (m_if.BVALID && m_if.BREADY) m_if.BVALID <= 1'b0;
      if (b_pend && !b_hold) begin
        m_if.BVALID <= 1'b1; m_if.BRESP <= b_resp_cfg; b_pend <= 1'b0;
      end
      if (commit) begin
        mem[c_addr[5:2]] <= merge(mem[c_addr[5:2]], c_data, c_strb);
        aw_got <= 1'b0; w_got <= 1'b0;
        if (!b_hold) begin
          m_if.BVALID <= 1'b1; m_if.BRESP <= b_resp_cfg;
        end else begin
          b_pend <= 1'b1;
        end
      end else begin
        if (aw_fire) begin aw_got <= 1'b1; sa_addr <= m_if.AWADDR; end
        if (w_fire) begin w_got <= 1'b1; sw_data <= m_if.WDATA; sw_strb <= m_if.WSTRB; end
      end
      if (m_if.RVALID && m_if.RREADY) m_if.RVALID <= 1'b0;
      if (m_if.ARVALID && m_if.ARREADY) begin
        rd_addr <= m_if.ARADDR;
        if (r_delay == 0) begin
          m_if.RVALID <= 1'b1; m_if.RDATA <= mem[m_if.ARADDR[5:2]]; m_if.RRESP <= r_resp_cfg;
        end else begin
          r_cnt <= r_delay;
        end
      end else if (r_cnt != 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) begin
          m_if.RVALID <= 1'b1; m_if.RDATA <= mem[rd_addr[5:2]]; m_if.RRESP <= r_resp_cfg;
        end
      end
    end
  end

  // Handshake counters and payload-stability monitor
  int   aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_seen = 0, stab_err = 0;
  logic aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
  logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;
  logic [3:0]  ws_prev = '0;

  always @(posedge CLK) begin
    if (aw_fire) aw_hs <= aw_hs + 1;
    if (w_fire) w_hs <= w_hs + 1;
    if (m_if.BVALID && m_if.BREADY) b_hs <= b_hs + 1;
    if (m_if.ARVALID && m_if.ARREADY) ar_hs <= ar_hs + 1;
    if (m_if.RVALID && m_if.RREADY) r_hs <= r_hs + 1;
    if (RSP_VALID) rsp_seen <= rsp_seen + 1;
    if (RST) begin
      aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
    end else begin
      if ((aw_stall && (!m_if.AWVALID || m_if.AWADDR !== aw_prev)) ||
          (w_stall && (!m_if.WVALID || m_if.WDATA !== w_prev || m_if.WSTRB !== ws_prev)) ||
          (ar_stall && (!m_if.ARVALID || m_if.ARADDR !== ar_prev)))
        stab_err <= stab_err + 1;
      aw_stall <= m_if.AWVALID && !m_if.AWREADY; aw_prev <= m_if.AWADDR;
      w_stall  <= m_if.WVALID && !m_if.WREADY;   w_prev  <= m_if.WDATA; ws_prev <= m_if.WSTRB;
      ar_stall <= m_if.ARVALID && !m_if.ARREADY; ar_prev <= m_if.ARADDR;
    end
  end

  // Issue one request; lat counts cycles from the accept edge to the RSP_VALID cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat, output logic err,
                        output logic [31:0] rdata, output logic pulse_ok);
    int n;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = data; REQ_WSTRB = strb;
    n = 0;
    while (!REQ_READY && n < 100) begin @(negedge CLK); n++; end
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 100) begin @(negedge CLK); lat++; end
    err = RSP_ERR;
    rdata = RSP_RDATA;
    @(negedge CLK);
    pulse_ok = !RSP_VALID;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if ({m_if.AWVALID, m_if.WVALID, m_if.ARVALID, m_if.BREADY, m_if.RREADY, RSP_VALID, RSP_ERR} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000000",
        {m_if.AWVALID, m_if.WVALID, m_if.ARVALID, m_if.BREADY, m_if.RREADY, RSP_VALID, RSP_ERR});
    end
    total++;
    if (REQ_READY !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", REQ_READY); end
    total++;
    if (RSP_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=00000000", RSP_RDATA); end
    total++;
    if ({m_if.AWADDR, m_if.WDATA, m_if.WSTRB} !== 68'h0) begin
      bad++; $display("FAIL reset_latches got=%h/%h/%h want=0", m_if.AWADDR, m_if.WDATA, m_if.WSTRB);
    end
    total++;
    if ({m_if.AWPROT, m_if.ARPROT} !== 6'b0) begin
      bad++; $display("FAIL prot got=%b want=000000", {m_if.AWPROT, m_if.ARPROT});
    end
  endtask

  task automatic test_write_read();
    int lat, r0; logic err, pulse; logic [31:0] rd;
    r0 = rsp_seen;
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, err, rd, pulse);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
    total++;
    if (!pulse || rsp_seen - r0 !== 1) begin
      bad++; $display("FAIL wr_rsp_pulse got=%0d pulses (single=%b) want=1", rsp_seen - r0, pulse);
    end
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, err, rd, pulse);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rd); end
    total++;
    if (lat !== 3 || !pulse) begin bad++; $display("FAIL rd_latency got=%0d single=%b want=3/1", lat, pulse); end
  endtask

  task automatic test_partial_write();
    int lat; logic err, pulse; logic [31:0] rd;
    do_req(1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, lat, err, rd, pulse);
    total++;
    if (RSP_RDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rdata_hold got=%h want=deadbeef", RSP_RDATA); end
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, err, rd, pulse);
    total++;
    if (rd !== 32'hDEAD_ABEF) begin bad++; $display("FAIL partial_rd got=%h want=deadabef", rd); end
  endtask

  task automatic test_zero_strobe();
    int lat, a0; logic err, pulse; logic [31:0] rd;
    a0 = aw_hs;
    do_req(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, lat, err, rd, pulse);
    total++;
    if (aw_hs - a0 !== 1 || lat !== 3) begin
      bad++; $display("FAIL zero_strb_issue got=%0d aw lat=%0d want=1 aw lat=3", aw_hs - a0, lat);
    end
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, err, rd, pulse);
    total++;
    if (rd !== 32'hDEAD_ABEF) begin bad++; $display("FAIL zero_strb_rd got=%h want=deadabef", rd); end
  endtask

  task automatic test_channel_order();
    int unsigned awd [3] = '{3, 0, 2};
    int unsigned wd  [3] = '{0, 3, 2};
    int          el  [3] = '{6, 6, 5};
    int lat, a0, w0, r0; logic err, pulse; logic [31:0] rd, wdat;
    for (int i = 0; i < 3; i++) begin
      aw_delay = awd[i]; w_delay = wd[i];
      a0 = aw_hs; w0 = w_hs; r0 = rsp_seen;
      wdat = 32'hC0DE_0000 + 32'(i);
      do_req(1'b1, 32'h0000_0020 + 32'(i * 4), wdat, 4'hF, lat, err, rd, pulse);
      total++;
      if (aw_hs - a0 !== 1 || w_hs - w0 !== 1 || rsp_seen - r0 !== 1 || lat !== el[i] || !pulse) begin
        bad++; $display("FAIL order_%0d got aw=%0d w=%0d rsp=%0d lat=%0d want 1/1/1 lat=%0d",
          i, aw_hs - a0, w_hs - w0, rsp_seen - r0, lat, el[i]);
      end
      aw_delay = 0; w_delay = 0;
      do_req(1'b0, 32'h0000_0020 + 32'(i * 4), 32'h0, 4'h0, lat, err, rd, pulse);
      total++;
      if (rd !== wdat) begin bad++; $display("FAIL order_rd_%0d got=%h want=%h", i, rd, wdat); end
    end
    total++;
    if (stab_err !== 0) begin bad++; $display("FAIL payload_stable got=%0d violations want=0", stab_err); end
  endtask

  task automatic test_stall_back_to_back();
    int lat, lat2, rr, busy, a0; logic err, pulse; logic [31:0] rd;
    r_delay = 5;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h0000_0010;
    @(posedge CLK);
    @(negedge CLK);
    REQ_WE = 1'b1; REQ_ADDR = 32'h0000_0030; REQ_WDATA = 32'h1234_5678; REQ_WSTRB = 4'hF;
    a0 = aw_hs; lat = 1; rr = 0; busy = 0;
    while (!RSP_VALID && lat < 100) begin
      if (REQ_READY) busy++;
      if (m_if.RREADY) rr++;
      @(negedge CLK); lat++;
    end
    total++;
    if (lat !== 8 || rr !== 6) begin bad++; $display("FAIL stall_rd got lat=%0d rready=%0d want 8/6", lat, rr); end
    total++;
    if (busy !== 0 || aw_hs !== a0) begin
      bad++; $display("FAIL busy_block got ready_cycles=%0d early_aw=%0d want 0/0", busy, aw_hs - a0);
    end
    total++;
    if (RSP_RDATA !== 32'hDEAD_ABEF || REQ_READY !== 1'b1) begin
      bad++; $display("FAIL stall_rsp got=%h ready=%b want=deadabef/1", RSP_RDATA, REQ_READY);
    end
    r_delay = 0;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    lat2 = 1;
    while (!RSP_VALID && lat2 < 100) begin @(negedge CLK); lat2++; end
    total++;
    if (lat2 !== 3 || aw_hs - a0 !== 1) begin
      bad++; $display("FAIL back_to_back got lat=%0d aw=%0d want 3/1", lat2, aw_hs - a0);
    end
    do_req(1'b0, 32'h0000_0030, 32'h0, 4'h0, lat, err, rd, pulse);
    total++;
    if (rd !== 32'h1234_5678) begin bad++; $display("FAIL b2b_rd got=%h want=12345678", rd); end
  endtask

  task automatic test_error();
    int lat; logic err, pulse, exp_err; logic [31:0] rd;
`ifdef AXI_MASTER_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    r_resp_cfg = 2'b10;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, err, rd, pulse);
    r_resp_cfg = 2'b00;
    total++;
    if (err !== exp_err) begin bad++; $display("FAIL rresp_err got=%b want=%b", err, exp_err); end
    total++;
    if (RSP_ERR !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", RSP_ERR); end
    b_resp_cfg = 2'b11;
    do_req(1'b1, 32'h0000_0034, 32'h5555_AAAA, 4'hF, lat, err, rd, pulse);
    b_resp_cfg = 2'b00;
    total++;
    if (err !== exp_err) begin bad++; $display("FAIL bresp_err got=%b want=%b", err, exp_err); end
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, err, rd, pulse);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL okay_err got=%b want=0", err); end
  endtask

  task automatic test_reset_in_wb();
    int n, r0;
    b_hold = 1'b1;
    r0 = rsp_seen;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h0000_0038; REQ_WDATA = 32'h0BAD_F00D; REQ_WSTRB = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 0;
    while (!m_if.BREADY && n < 20) begin @(negedge CLK); n++; end
    total++;
    if (m_if.BREADY !== 1'b1) begin bad++; $display("FAIL reach_wb got bready=%b want=1", m_if.BREADY); end
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({m_if.AWVALID, m_if.WVALID, m_if.ARVALID, m_if.BREADY, m_if.RREADY, REQ_READY} !== 6'b000001) begin
      bad++; $display("FAIL rst_in_wb got=%b want=000001",
        {m_if.AWVALID, m_if.WVALID, m_if.ARVALID, m_if.BREADY, m_if.RREADY, REQ_READY});
    end
    b_hold = 1'b0;
    repeat (6) @(negedge CLK);
    total++;
    if (rsp_seen !== r0) begin bad++; $display("FAIL rst_no_rsp got=%0d pulses want=0", rsp_seen - r0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_zero_strobe();
    test_channel_order();
    test_stall_back_to_back();
    test_error();
    test_reset_in_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
